fe_tobytes: RTL and testbench

FE_TOBYTES -- requirements
Module: fe_tobytes

---
 rtl/fe_pkg.sv | 26 ++
 rtl/fe_limb_carry.sv | 21 ++
 rtl/fe_tobytes.sv | 170 +++++++++++++++++
 tb/tb_fe_tobytes.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// fe_pkg: constants and types shared by the field-element serializer.
// Limb layout follows the radix-2^25.5 representation: even limbs carry
// 26 bits, odd limbs 25 bits, for 255 bits in total.
package fe_pkg;

    localparam int FE_LIMBS = 10;

    // Width of the internal signed arithmetic; wide enough that 32-bit
    // signed input limbs plus carries and 19*q never overflow.
    localparam int DATA_W = 40;

    localparam int LIMB_W   [FE_LIMBS] = '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};
    localparam int LIMB_OFF [FE_LIMBS] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

    // Field prime 2^255 - 19.
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    typedef enum logic [2:0] {
        IDLE,
        QRED,
        FOLD,
        CARRY,
        PACK
    } state_t;

endpackage

// File: rtl/fe_limb_carry.sv
// fe_limb_carry: one signed limb step of width w.
// sum = h + cin; c = floor(sum / 2^w); rem = sum - c*2^w (always in [0, 2^w)).
// The quotient reduction uses c with cin = q; the carry chain uses both
// outputs with cin = 0.
module fe_limb_carry
    import fe_pkg::*;
(
    input  logic signed [DATA_W-1:0] h,
    input  logic signed [DATA_W-1:0] cin,
    input  logic        [4:0]        w,
    output logic signed [DATA_W-1:0] c,
    output logic signed [DATA_W-1:0] rem
);

    logic signed [DATA_W-1:0] sum;

    assign sum = h + cin;
    assign c   = sum >>> w;
    assign rem = sum - (c <<< w);

endmodule

// File: rtl/fe_tobytes.sv
// fe_tobytes: serializes a 10-limb signed field element into its canonical
// 32-byte little-endian encoding. The work is sequential: 10 quotient steps,
// one fold of 19*q into limb 0, 10 carry steps, and one pack cycle, giving a
// fixed latency of 22 cycles from the accept edge to done.
// Optional build macro: FE_TOBYTES_CANON_FLAG_EN adds the `canon` output,
// which reports whether the input value was already below p.
module fe_tobytes
    import fe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [319:0] z,
    output logic [255:0] out,
    output logic         done,
    output logic         busy
`ifdef FE_TOBYTES_CANON_FLAG_EN
    ,
    output logic         canon
`endif
);

    state_t state, state_nx;

    logic        [3:0]        cnt;
    logic signed [DATA_W-1:0] h [FE_LIMBS];
    logic signed [DATA_W-1:0] q;

    logic signed [DATA_W-1:0] h9_in;
    logic signed [DATA_W-1:0] q_init;
    logic signed [DATA_W-1:0] step_h;
    logic signed [DATA_W-1:0] step_cin;
    logic signed [DATA_W-1:0] step_c;
    logic signed [DATA_W-1:0] step_rem;
    logic        [4:0]        step_w;
    logic                     start;
    logic                     last;
    logic        [255:0]      packed_val;

    function automatic logic signed [DATA_W-1:0] sext_limb(input logic [31:0] v);
        return {{(DATA_W-32){v[31]}}, v};
    endfunction

    // After the carry chain every limb is in [0, 2^w), so its low 26 bits
    // hold the whole value (bit 25 is zero for the 25-bit limbs).
    function automatic logic [255:0] place_limb(input logic signed [DATA_W-1:0] limb,
                                                input int off);
        return 256'(limb[25:0]) << off;
    endfunction

    // A start is refused in the done cycle so a new operation only begins
    // from a clean IDLE cycle.
    assign start    = (state == IDLE) && valid && !done;
    assign last     = (cnt == 4'd9);

    // Initial quotient estimate from the top limb: round(19*h9 / 2^25).
    assign h9_in    = sext_limb(z[319:288]);
    assign q_init   = (h9_in * 40'sd19 + 40'sd16777216) >>> 25;

    // Shared step unit: selected limb, with q fed in only during QRED.
    assign step_h   = h[cnt];
    assign step_cin = (state == QRED) ? q : '0;
    assign step_w   = 5'(LIMB_W[cnt]);

    fe_limb_carry u_step (
        .h   (step_h),
        .cin (step_cin),
        .w   (step_w),
        .c   (step_c),
        .rem (step_rem)
    );

    // Concatenate the normalized limbs at their bit offsets.
    always_comb begin
        packed_val = '0;
        for (int i = 0; i < FE_LIMBS; i++) begin
            packed_val = packed_val | place_limb(h[i], LIMB_OFF[i]);
        end
    end

    // State register for the reduction sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: two fixed 10-step loops bracketed by single-cycle stages.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = QRED;
            QRED:    if (last)  state_nx = FOLD;
            FOLD:    state_nx = CARRY;
            CARRY:   if (last)  state_nx = PACK;
            PACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Step counter, limb registers, quotient and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            q    <= '0;
            out  <= '0;
            done <= 1'b0;
            busy <= 1'b0;
            for (int i = 0; i < FE_LIMBS; i++) begin
                h[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < FE_LIMBS; i++) begin
                            h[i] <= sext_limb(z[32*i +: 32]);
                        end
                        q    <= q_init;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                QRED: begin
                    q   <= step_c;
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                end
                FOLD: begin
                    h[0] <= h[0] + q * 40'sd19;
                    cnt  <= '0;
                end
                CARRY: begin
                    // The carry out of limb 9 has no destination: that is the
                    // reduction modulo 2^255.
                    for (int i = 0; i < FE_LIMBS; i++) begin
                        if (4'(i) == cnt) begin
                            h[i] <= step_rem;
                        end else if (4'(i) == cnt + 4'd1) begin
                            h[i] <= h[i] + step_c;
                        end
                    end
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                end
                PACK: begin
                    out  <= packed_val;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FE_TOBYTES_CANON_FLAG_EN
    // A zero final quotient means no multiple of p had to be removed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            canon <= 1'b0;
        end else if (state == PACK) begin
            canon <= (q == '0);
        end
    end
`endif

endmodule

// File: tb/tb_fe_tobytes.sv
// tb_fe_tobytes: scoreboard bench for fe_tobytes. The stimulus side pushes the
// expected encoding for every accepted start; a negedge monitor pops and
// compares whenever done is high. Expected values come from big-integer
// arithmetic on the limb value (not from the limb-by-limb procedure).
module tb_fe_tobytes;

    localparam int OFF [10] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};
    localparam logic [255:0] PB = (256'd1 << 255) - 256'd19;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         valid = 1'b0;
    logic [319:0] z     = '0;
    logic [255:0] out;
    logic         done;
    logic         busy;
`ifdef FE_TOBYTES_CANON_FLAG_EN
    logic         canon;
`endif

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        logic [255:0] o;
        logic         cn;
        int           st;
    } exp_t;

    exp_t sb [$];

    fe_tobytes dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .z     (z),
        .out   (out),
        .done  (done),
        .busy  (busy)
`ifdef FE_TOBYTES_CANON_FLAG_EN
        ,
        .canon (canon)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Integer value of the limb vector: sum of signed limb_i * 2^off_i.
    function automatic logic signed [299:0] limb_value(input logic [319:0] zz);
        logic signed [299:0] v;
        logic signed [299:0] t;
        logic signed [31:0]  l;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            l = zz[32*i +: 32];
            t = l;
            v = v + (t <<< OFF[i]);
        end
        return v;
    endfunction

    // General rule for any 32-bit limbs: q = floor((V + q0) / 2^255),
    // result = (V + 19q) mod 2^255.
    function automatic void model_gen(input logic [319:0] zz, output logic [255:0] o,
                                      output logic cn);
        logic signed [299:0] v, t9, q0, q, r;
        logic signed [31:0]  l9;
        v  = limb_value(zz);
        l9 = zz[319:288];
        t9 = l9;
        q0 = (t9 * 300'sd19 + 300'sd16777216) >>> 25;
        q  = (v + q0) >>> 255;
        r  = v + q * 300'sd19;
        o  = {1'b0, r[254:0]};
        cn = (q == 0);
    endfunction

    // For limbs within their nominal ranges the result is just V mod p.
    function automatic void model_mod(input logic [319:0] zz, output logic [255:0] o,
                                      output logic cn);
        logic signed [299:0] v, ps, r;
        v  = limb_value(zz);
        ps = {44'd0, PB};
        r  = v % ps;
        if (r < 0) r = r + ps;
        o  = r[255:0];
        cn = (v >= 0) && (v < ps);
    endfunction

    function automatic logic [319:0] rand_full();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [319:0] rand_nominal();
        logic [319:0] r;
        for (int i = 0; i < 10; i++)
            r[32*i +: 32] = $urandom() & ((i % 2 == 0) ? 32'h03ffffff : 32'h01ffffff);
        return r;
    endfunction

    // Present one cycle of valid/z; optionally record the expected result.
    task automatic drive(input logic v, input logic [319:0] zz, input logic push,
                         input logic [255:0] eo, input logic ec);
        @(negedge clk);
        valid = v;
        z     = zz;
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (push) sb.push_back('{eo, ec, cyc});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done) && n < 60);
        chk_i("idle_within_bound", int'(busy | done), 0);
    endtask

    task automatic op(input logic [319:0] zz, input logic [255:0] eo, input logic ec);
        drive(1'b1, zz, 1'b1, eo, ec);
        chk_i("busy_set", int'(busy), 1);
        wait_idle();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin : mon
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                e = sb.pop_front();
                chk_w("out", out, e.o);
                chk_i("latency", cyc - e.st, 22);
`ifdef FE_TOBYTES_CANON_FLAG_EN
                chk_i("canon", int'(canon), int'(e.cn));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected run to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [319:0] zp, zp1, zm1, zmax, zv, za, zb, zc, zz;
        logic [255:0] eo, o_prev;
        logic         ec;
        int           d0;

        // Reset with valid held high: reset must win.
        rst   = 1'b0;
        valid = 1'b1;
        z     = rand_full();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_w("reset_out", out, '0);
        chk_i("reset_done", int'(done), 0);
        chk_i("reset_busy", int'(busy), 0);
`ifdef FE_TOBYTES_CANON_FLAG_EN
        chk_i("reset_canon", int'(canon), 0);
`endif
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk_i("idle_after_reset", int'(busy), 0);

        // Directed boundary values.
        zp = '0;
        for (int i = 0; i < 10; i++)
            zp[32*i +: 32] = (i == 0) ? 32'h03ffffed : ((i % 2 == 1) ? 32'h01ffffff : 32'h03ffffff);
        zp1 = zp;
        zp1[31:0] = 32'h03ffffee;
        zm1 = '0;
        zm1[31:0] = 32'hffffffff;
        zmax = zp;
        zmax[31:0] = 32'h03ffffff;

        op('0,   256'd0,       1'b1);
        op(zp,   256'd0,       1'b0);
        op(zp1,  256'd1,       1'b0);
        op(zm1,  PB - 256'd1,  1'b0);
        op(zmax, 256'd18,      1'b0);

        zv = 320'h0049fd2ffe92c0caff7a034e003fbc9000d7170cfecb467cff5d81fb004677270053346e01027c28;
        model_gen(zv, eo, ec);
        op(zv, eo, ec);

        // Randomized: arbitrary 32-bit limbs and nominal-range limbs.
        for (int n = 0; n < 200; n++) begin
            zz = rand_full();
            model_gen(zz, eo, ec);
            op(zz, eo, ec);
            zz = rand_nominal();
            model_mod(zz, eo, ec);
            op(zz, eo, ec);
        end

        // Starts while busy and in the done cycle are dropped; the next one is taken.
        za = rand_full();
        zb = rand_full();
        zc = rand_nominal();
        model_gen(za, eo, ec);
        drive(1'b1, za, 1'b1, eo, ec);
        o_prev = out;
        model_mod(zc, eo, ec);
        for (int k = 0; k <= 23; k++) begin
            @(negedge clk);
            if (k == 21) chk_w("out_hold", out, o_prev);
            if (k == 22) chk_i("busy_on_done", int'(busy), 1);
            if (k == 23) chk_i("busy_clear", int'(busy), 0);
            valid = (k == 5 || k == 22 || k == 23);
            z     = (k == 23) ? zc : zb;
            @(posedge clk);
            #1;
            valid = 1'b0;
            if (k == 23) sb.push_back('{eo, ec, cyc});
        end
        wait_idle();

        // Reset in the middle of an operation abandons it silently.
        drive(1'b1, rand_full(), 1'b0, '0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_w("abort_out", out, '0);
        chk_i("abort_busy", int'(busy), 0);
        chk_i("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        chk_i("abort_no_done", done_cnt, d0);

        zz = rand_full();
        model_gen(zz, eo, ec);
        op(zz, eo, ec);

        repeat (5) @(posedge clk);
        chk_i("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
